// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package irq_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Width of a source ID: at least one bit even for two sources.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/irq_prio_arbiter.sv
// Combinational priority arbiter: picks the highest-priority eligible
// source with a balanced compare tree; equal priorities go to the lower index.
module irq_prio_arbiter
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQS = 8,
  parameter int PRIO_W   = 3,
  localparam int ID_W    = id_width(NUM_IRQS)
) (
  input  logic [NUM_IRQS-1:0]        eligible,
  input  logic [NUM_IRQS*PRIO_W-1:0] prio,
  output logic                       valid,
  output logic [ID_W-1:0]            id,
  output logic [PRIO_W-1:0]          prio_out
);

  // Tree is padded to a power of two; padded leaves are never valid.
  localparam int LEAVES = 1 << ID_W;

  genvar l, j;
  generate
    for (l = 0; l <= ID_W; l++) begin : g_lvl
      logic [(1<<l)-1:0]             w_v;
      logic [(1<<l)-1:0][ID_W-1:0]   w_id;
      logic [(1<<l)-1:0][PRIO_W-1:0] w_p;

      if (l == ID_W) begin : g_leaf
        for (j = 0; j < LEAVES; j++) begin : g_node
          if (j < NUM_IRQS) begin : g_src
            assign w_v[j]  = eligible[j];
            assign w_id[j] = ID_W'(j);
            assign w_p[j]  = prio[j*PRIO_W +: PRIO_W];
          end else begin : g_pad
            assign w_v[j]  = 1'b0;
            assign w_id[j] = ID_W'(j);
            assign w_p[j]  = {PRIO_W{1'b0}};
          end
        end
      end else begin : g_merge
        for (j = 0; j < (1 << l); j++) begin : g_node
          logic w_take_left;
          // Left child covers lower indices, so it wins ties.
          assign w_take_left = g_lvl[l+1].w_v[2*j] &
                               (~g_lvl[l+1].w_v[2*j+1] |
                                (g_lvl[l+1].w_p[2*j] >= g_lvl[l+1].w_p[2*j+1]));
          assign w_v[j]  = g_lvl[l+1].w_v[2*j] | g_lvl[l+1].w_v[2*j+1];
          assign w_id[j] = w_take_left ? g_lvl[l+1].w_id[2*j] : g_lvl[l+1].w_id[2*j+1];
          assign w_p[j]  = w_take_left ? g_lvl[l+1].w_p[2*j]  : g_lvl[l+1].w_p[2*j+1];
        end
      end
    end
  endgenerate

  assign valid    = g_lvl[0].w_v[0];
  assign id       = g_lvl[0].w_id[0];
  assign prio_out = g_lvl[0].w_p[0];

endmodule

// File: rtl/prio_interrupt_controller.sv
// Priority interrupt controller: synchroniser, edge/level trigger, pending
// register, priority arbitration and a claim/complete service FSM.
module prio_interrupt_controller
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_IRQS    = 8,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = id_width(NUM_IRQS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IRQS-1:0]        irq,
  input  logic [NUM_IRQS-1:0]        ier,
  input  logic [NUM_IRQS-1:0]        edge_sel,
  input  logic [NUM_IRQS*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]          threshold,
  input  logic                       claim,
  input  logic                       complete,
  output logic [NUM_IRQS-1:0]        pending,
  output logic                       inter,
  output logic [ID_W-1:0]            irq_id,
  output logic [PRIO_W-1:0]          irq_prio,
  output logic                       busy,
  output logic [ID_W-1:0]            active_id
);

  logic [NUM_IRQS-1:0] w_s;
  logic [NUM_IRQS-1:0] r_s_prev;
  logic [NUM_IRQS-1:0] w_rise;
  logic [NUM_IRQS-1:0] w_trig;
  logic [NUM_IRQS-1:0] w_clr;
  logic [NUM_IRQS-1:0] w_eligible;
  logic [NUM_IRQS-1:0] r_pending;

  logic                w_arb_valid;
  logic [ID_W-1:0]     w_arb_id;
  logic [PRIO_W-1:0]   w_arb_prio;

  irq_state_e          r_state;
  irq_state_e          w_state_nxt;
  logic                r_inter;
  logic                r_busy;
  logic [ID_W-1:0]     r_irq_id;
  logic [ID_W-1:0]     w_irq_id_nxt;
  logic [PRIO_W-1:0]   r_irq_prio;
  logic [PRIO_W-1:0]   w_irq_prio_nxt;
  logic [ID_W-1:0]     r_active_id;
  logic [ID_W-1:0]     w_active_id_nxt;
  logic                w_claim_acc;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = irq;
    end else begin : g_sync
      logic [NUM_IRQS-1:0] r_sync [SYNC_STAGES];

      // Shift raw requests through the synchroniser chain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= {NUM_IRQS{1'b0}};
        end else begin
          r_sync[0] <= irq;
          for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
      end

      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Remember the previous synchronised level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s_prev <= {NUM_IRQS{1'b0}};
    else        r_s_prev <= w_s;
  end

  assign w_rise = w_s & ~r_s_prev;
  assign w_trig = ier & ((edge_sel & w_rise) | (~edge_sel & w_s));

  // Only the source being claimed is cleared, and only when the claim is accepted.
  assign w_clr = w_claim_acc ? ({{(NUM_IRQS-1){1'b0}}, 1'b1} << r_irq_id)
                             : {NUM_IRQS{1'b0}};

  // Pending bits: a new trigger beats a same-cycle clear so no event is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= {NUM_IRQS{1'b0}};
    else        r_pending <= w_trig | (r_pending & ~w_clr);
  end

  // A source competes only if pending, enabled and above the threshold.
  always_comb begin
    w_eligible = {NUM_IRQS{1'b0}};
    for (int i = 0; i < NUM_IRQS; i++) begin
      w_eligible[i] = r_pending[i] & ier[i] & (prio[i*PRIO_W +: PRIO_W] > threshold);
    end
  end

  irq_prio_arbiter #(
    .NUM_IRQS (NUM_IRQS),
    .PRIO_W   (PRIO_W)
  ) u_arb (
    .eligible (w_eligible),
    .prio     (prio),
    .valid    (w_arb_valid),
    .id       (w_arb_id),
    .prio_out (w_arb_prio)
  );

  // Next-state and next-output decode for the service FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_irq_id_nxt    = r_irq_id;
    w_irq_prio_nxt  = r_irq_prio;
    w_active_id_nxt = r_active_id;
    w_claim_acc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt    = REQ;
          w_irq_id_nxt   = w_arb_id;
          w_irq_prio_nxt = w_arb_prio;
        end else begin
          w_state_nxt    = IDLE;
        end
      end
      REQ: begin
        if (!w_arb_valid) begin
          w_state_nxt     = IDLE;
        end else if (claim) begin
          // Service the winner the CPU actually saw on irq_id.
          w_claim_acc     = 1'b1;
          w_active_id_nxt = r_irq_id;
          w_state_nxt     = SERVICE;
        end else begin
          w_irq_id_nxt    = w_arb_id;
          w_irq_prio_nxt  = w_arb_prio;
        end
      end
      SERVICE: begin
        if (complete) w_state_nxt = IDLE;
        else          w_state_nxt = SERVICE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; inter/busy are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_inter     <= 1'b0;
      r_busy      <= 1'b0;
      r_irq_id    <= {ID_W{1'b0}};
      r_irq_prio  <= {PRIO_W{1'b0}};
      r_active_id <= {ID_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_inter     <= (w_state_nxt == REQ);
      r_busy      <= (w_state_nxt == SERVICE);
      r_irq_id    <= w_irq_id_nxt;
      r_irq_prio  <= w_irq_prio_nxt;
      r_active_id <= w_active_id_nxt;
    end
  end

  assign pending   = r_pending;
  assign inter     = r_inter;
  assign irq_id    = r_irq_id;
  assign irq_prio  = r_irq_prio;
  assign busy      = r_busy;
  assign active_id = r_active_id;

endmodule

// File: tb/tb_prio_interrupt_controller.sv
// Directed self-checking bench for prio_interrupt_controller (8 sources,
// 3-bit priority, 2 synchroniser stages).
module tb_prio_interrupt_controller;

  localparam int N  = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic [N-1:0]  ier = '0;
  logic [N-1:0]  edge_sel = '0;
  logic [N*PW-1:0] prio = '0;
  logic [PW-1:0] threshold = '0;
  logic          claim = 1'b0;
  logic          complete = 1'b0;
  logic [N-1:0]  pending;
  logic          inter;
  logic [2:0]    irq_id;
  logic [PW-1:0] irq_prio;
  logic          busy;
  logic [2:0]    active_id;

  int n_tests = 0;
  int n_fail  = 0;

  prio_interrupt_controller #(.NUM_IRQS(N), .PRIO_W(PW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .ier(ier), .edge_sel(edge_sel),
    .prio(prio), .threshold(threshold), .claim(claim), .complete(complete),
    .pending(pending), .inter(inter), .irq_id(irq_id), .irq_prio(irq_prio),
    .busy(busy), .active_id(active_id)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq = '0; ier = '0; edge_sel = '0; prio = '0;
    threshold = '0; claim = 1'b0; complete = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({pending, inter, irq_id, irq_prio, busy, active_id} !== '0) begin
      $display("FAIL reset_outputs: got %h required 0", {pending, inter, irq_id, irq_prio, busy, active_id});
      n_fail++;
    end
    step(3);
    n_tests++;
    if (inter !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL reset_idle: inter=%b busy=%b required 0 0", inter, busy); n_fail++;
    end
  endtask

  task automatic test_level();
    do_reset();
    ier[2] = 1'b1; prio[2*PW +: PW] = 3'd3; irq[2] = 1'b1;
    step(3);
    n_tests++;
    if (pending !== 8'h04 || inter !== 1'b0) begin
      $display("FAIL level_pending: pending=%h inter=%b required 04 0", pending, inter); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd2 || irq_prio !== 3'd3) begin
      $display("FAIL level_inter: inter=%b id=%0d prio=%0d required 1 2 3", inter, irq_id, irq_prio); n_fail++;
    end
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || inter !== 1'b0 || active_id !== 3'd2 || pending[2] !== 1'b1) begin
      $display("FAIL level_claim: busy=%b inter=%b act=%0d pend2=%b required 1 0 2 1", busy, inter, active_id, pending[2]); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL level_no_reint: inter=%b busy=%b required 0 1", inter, busy); n_fail++;
    end
    complete = 1'b1; step(1); complete = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || inter !== 1'b0) begin
      $display("FAIL level_complete: busy=%b inter=%b required 0 0", busy, inter); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd2) begin
      $display("FAIL level_reassert: inter=%b id=%0d required 1 2", inter, irq_id); n_fail++;
    end
  endtask

  task automatic test_edge_prio();
    do_reset();
    ier = 8'h22; edge_sel = 8'h22;
    prio[1*PW +: PW] = 3'd2; prio[5*PW +: PW] = 3'd6;
    irq = 8'h22; step(1); irq = '0; step(3);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd5 || irq_prio !== 3'd6 || pending !== 8'h22) begin
      $display("FAIL edge_first: inter=%b id=%0d prio=%0d pend=%h required 1 5 6 22", inter, irq_id, irq_prio, pending); n_fail++;
    end
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || active_id !== 3'd5 || pending !== 8'h02) begin
      $display("FAIL edge_claim: busy=%b act=%0d pend=%h required 1 5 02", busy, active_id, pending); n_fail++;
    end
    complete = 1'b1; step(1); complete = 1'b0; step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd1 || irq_prio !== 3'd2) begin
      $display("FAIL edge_second: inter=%b id=%0d prio=%0d required 1 1 2", inter, irq_id, irq_prio); n_fail++;
    end
  endtask

  task automatic test_tie_threshold();
    do_reset();
    ier = 8'h48;
    prio[3*PW +: PW] = 3'd4; prio[6*PW +: PW] = 3'd4;
    irq = 8'h48; step(4);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd3) begin
      $display("FAIL tie_low_index: inter=%b id=%0d required 1 3", inter, irq_id); n_fail++;
    end
    threshold = 3'd4; step(3);
    n_tests++;
    if (inter !== 1'b0 || pending !== 8'h48) begin
      $display("FAIL threshold_mask: inter=%b pend=%h required 0 48", inter, pending); n_fail++;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    ier = 8'h82; edge_sel = 8'h02;
    prio[1*PW +: PW] = 3'd2; prio[7*PW +: PW] = 3'd7;
    irq[1] = 1'b1; step(1); irq[1] = 1'b0; step(3);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd1) begin
      $display("FAIL preempt_initial: inter=%b id=%0d required 1 1", inter, irq_id); n_fail++;
    end
    irq[7] = 1'b1; step(3);
    n_tests++;
    if (irq_id !== 3'd1 || pending !== 8'h82) begin
      $display("FAIL preempt_before: id=%0d pend=%h required 1 82", irq_id, pending); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd7 || irq_prio !== 3'd7) begin
      $display("FAIL preempt_switch: inter=%b id=%0d prio=%0d required 1 7 7", inter, irq_id, irq_prio); n_fail++;
    end
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || active_id !== 3'd7 || pending[1] !== 1'b1) begin
      $display("FAIL preempt_claim: busy=%b act=%0d pend1=%b required 1 7 1", busy, active_id, pending[1]); n_fail++;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    ier[0] = 1'b1; edge_sel[0] = 1'b1; prio[0 +: PW] = 3'd5;
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (inter !== 1'b0 || busy !== 1'b0 || active_id !== 3'd0) begin
      $display("FAIL claim_in_idle: inter=%b busy=%b act=%0d required 0 0 0", inter, busy, active_id); n_fail++;
    end
    irq[0] = 1'b1; step(1); irq[0] = 1'b0; step(3);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd0 || pending !== 8'h01) begin
      $display("FAIL src0_req: inter=%b id=%0d pend=%h required 1 0 01", inter, irq_id, pending); n_fail++;
    end
    complete = 1'b1; step(1); complete = 1'b0;
    n_tests++;
    if (inter !== 1'b1 || busy !== 1'b0 || pending !== 8'h01) begin
      $display("FAIL complete_in_req: inter=%b busy=%b pend=%h required 1 0 01", inter, busy, pending); n_fail++;
    end
    irq[0] = 1'b1; step(1); irq[0] = 1'b0; step(1);
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || inter !== 1'b0 || pending[0] !== 1'b1) begin
      $display("FAIL edge_during_claim: busy=%b inter=%b pend0=%b required 1 0 1", busy, inter, pending[0]); n_fail++;
    end
    claim = 1'b1; complete = 1'b1; step(1); claim = 1'b0; complete = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || inter !== 1'b0) begin
      $display("FAIL claim_complete_service: busy=%b inter=%b required 0 0", busy, inter); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd0) begin
      $display("FAIL rearbitrate: inter=%b id=%0d required 1 0", inter, irq_id); n_fail++;
    end
  endtask

  task automatic test_reset_mid_service();
    do_reset();
    ier[4] = 1'b1; prio[4*PW +: PW] = 3'd3; irq[4] = 1'b1;
    step(4);
    claim = 1'b1; step(1); claim = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || active_id !== 3'd4) begin
      $display("FAIL rst_pre_service: busy=%b act=%0d required 1 4", busy, active_id); n_fail++;
    end
    rst_n = 1'b0; #1;
    n_tests++;
    if ({pending, inter, irq_id, irq_prio, busy, active_id} !== '0) begin
      $display("FAIL rst_mid_service: got %h required 0", {pending, inter, irq_id, irq_prio, busy, active_id}); n_fail++;
    end
    step(1); rst_n = 1'b1;
    step(3);
    n_tests++;
    if (inter !== 1'b0 || pending[4] !== 1'b1) begin
      $display("FAIL rst_retrig_pend: inter=%b pend4=%b required 0 1", inter, pending[4]); n_fail++;
    end
    step(1);
    n_tests++;
    if (inter !== 1'b1 || irq_id !== 3'd4 || busy !== 1'b0) begin
      $display("FAIL rst_retrig_inter: inter=%b id=%0d busy=%b required 1 4 0", inter, irq_id, busy); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge_prio();
    test_tie_threshold();
    test_preempt();
    test_same_cycle();
    test_reset_mid_service();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_interrupt_controller.md
# prio_interrupt_controller

Parametrised priority interrupt controller, the successor to the flat OR-combining controller. It adds per-source edge/level triggering, an input synchroniser, per-source priorities with a global threshold, and a claim/complete handshake exposing the winning source ID. It sits between peripheral IRQ lines and a single CPU interrupt input; software configuration arrives as static register-bank outputs.

## Interface
- NUM_IRQS, 8: number of sources, 2..64.
- PRIO_W, 3: priority width; priority 0 means never interrupt.
- SYNC_STAGES, 2: synchroniser flops on irq, 0..3; 0 means irq is already in the clk domain.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- irq  in  NUM_IRQS  raw interrupt requests.
- ier  in  NUM_IRQS  per-source enable.
- edge_sel  in  NUM_IRQS  1 = rising-edge trigger, 0 = level-high trigger.
- prio  in  NUM_IRQS*PRIO_W  per-source priority; source i occupies bits [i*PRIO_W +: PRIO_W].
- threshold  in  PRIO_W  only priorities strictly greater than this interrupt.
- claim  in  1  single-cycle claim pulse from the CPU.
- complete  in  1  single-cycle end-of-service pulse.
- pending  out  NUM_IRQS  pending register.
- inter  out  1  interrupt to CPU, registered.
- irq_id  out  ID_W  winning source; ID_W = max(1, $clog2(NUM_IRQS)).
- irq_prio  out  PRIO_W  priority of irq_id.
- busy  out  1  a claimed interrupt is in service.
- active_id  out  ID_W  ID of the source in service.

## Operation
- Synchroniser: SYNC_STAGES flops per bit, reset 0; output s.
- Edge detect: s_prev is a register of s, reset 0; rise = s & ~s_prev.
- Trigger: trig[i] = ier[i] & (edge_sel[i] ? rise[i] : s[i]).
- pending[i] next = trig[i] | (pending[i] & ~clr[i]); clr[i] is claim accepted for ID i. Set wins over clear, so a new edge during the claim cycle is not lost.
- Clearing ier does not clear pending; it masks eligibility only.
- eligible[i] = pending[i] & ier[i] & (prio[i] > threshold).
- Arbitration selects the highest priority eligible source. Ties go to the lowest index.
- FSM states IDLE, REQ, SERVICE; reset state IDLE.
- IDLE: inter=0. Any eligible source moves the FSM to REQ and loads irq_id/irq_prio.
- REQ: inter=1. irq_id/irq_prio re-register every cycle from arbitration, so a higher-priority arrival replaces the current winner.
  - No source eligible: go to IDLE.
  - claim: active_id <= irq_id, clear pending[irq_id], go to SERVICE.
- SERVICE: inter=0, busy=1. complete moves the FSM to IDLE, and re-arbitration happens from IDLE.
- claim outside REQ is ignored. complete outside SERVICE is ignored.
- claim and complete in the same cycle: only the one valid for the current state takes effect.
- Level source still high after its claim: pending re-sets on the next cycle but cannot re-interrupt until complete.

## Timing
- All outputs reset to 0. FSM resets to IDLE.
- Latency: irq first sampled high at edge 0 → pending set at edge SYNC_STAGES → inter=1 and irq_id valid after edge SYNC_STAGES+1.
- Claim at edge c → pending cleared, busy=1, inter=0 after edge c.
- Complete at edge d → busy=0 after d. If another source is eligible, inter=1 after d+1.
- inter, irq_id, irq_prio, busy and active_id are direct flop outputs.
- Reset mid-service drops all state. Sources still high or pending re-trigger normally after reset; edge sources trigger only on a new rising edge.

## Structure
- Package irq_ctrl_pkg holds:
  - typedef enum irq_state_e {IDLE, REQ, SERVICE};
  - function id_width(n).
- Sub-module irq_prio_arbiter(NUM_IRQS, PRIO_W): combinational. Inputs eligible and prio. Outputs valid, id and prio_out, built as a log2-depth compare tree with lowest-index tie-break.
- The top level contains the synchroniser, edge detect, pending register and FSM.

## Test plan
- Level, prio 3, threshold 0, SYNC_STAGES=2: irq[2] high at edge 0 → inter=1 and irq_id=2 after edge 3; claim → busy=1 and pending[2] re-sets while irq held; complete → inter reasserts after 2 edges.
- Edge sources 1 (prio 2) and 5 (prio 6) pulse together → irq_id=5 first; after claim and complete → irq_id=1.
- Equal priority 4 on sources 3 and 6 → irq_id=3. threshold=4 → inter stays 0 and pending stays set.
- In REQ with irq_id=1 (prio 2), source 7 (prio 7) arrives → irq_id changes to 7 before claim; claim services 7.
- Edge on source 0 in the same cycle as its claim → pending[0] remains 1. claim in IDLE and complete in REQ are ignored with no state change.
- Assert rst_n low during SERVICE → all outputs 0 and FSM IDLE; a held level source re-interrupts after SYNC_STAGES+1 edges.
